// File: rtl/gs_ddram_bridge.sv
// General Sound byte-wide memory port to 64-bit DDRAM bridge.
// One-line read cache; writes go straight through with a single byte lane enabled.
module gs_ddram_bridge #(
   parameter logic [28:0] DDR_BASE = 29'h6000000
) (
   input  logic        clk_sys,
   input  logic        reset,
   input  logic [20:0] addr,
   input  logic [7:0]  din,
   output logic [7:0]  dout,
   input  logic        rd,
   input  logic        wr,
   output logic        ready,
   input  logic        DDRAM_BUSY,
   output logic [7:0]  DDRAM_BURSTCNT,
   output logic [28:0] DDRAM_ADDR,
   input  logic [63:0] DDRAM_DOUT,
   input  logic        DDRAM_DOUT_READY,
   output logic        DDRAM_RD,
   output logic [63:0] DDRAM_DIN,
   output logic [7:0]  DDRAM_BE,
   output logic        DDRAM_WE
);

   typedef enum logic [1:0] {IDLE, RD_REQ, RD_WAIT, WR_REQ} state_t;

   state_t      state_q;
   logic        rd_hist_q;
   logic        wr_hist_q;
   logic [63:0] line_q;
   logic [17:0] tag_q;
   logic        valid_q;
   logic [17:0] req_tag_q;
   logic [2:0]  req_sel_q;
   logic [7:0]  dout_q;
   logic        ready_q;
   logic        ddram_rd_q;
   logic        ddram_we_q;
   logic [28:0] ddram_addr_q;
   logic [63:0] ddram_din_q;
   logic [7:0]  ddram_be_q;

   logic rd_edge;
   logic wr_edge;
   logic hit;

   function automatic logic [7:0] get_byte(input logic [63:0] w, input logic [2:0] s);
      return w[{s, 3'b000} +: 8];
   endfunction

   function automatic logic [63:0] put_byte(input logic [63:0] w, input logic [2:0] s,
                                            input logic [7:0] b);
      logic [63:0] r;
      r = w;
      r[{s, 3'b000} +: 8] = b;
      return r;
   endfunction

   assign rd_edge = rd & ~rd_hist_q;
   assign wr_edge = wr & ~wr_hist_q;
   assign hit     = valid_q & (tag_q == addr[20:3]);

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         state_q      <= IDLE;
         rd_hist_q    <= 1'b0;
         wr_hist_q    <= 1'b0;
         valid_q      <= 1'b0;
         dout_q       <= 8'd0;
         ready_q      <= 1'b1;
         ddram_rd_q   <= 1'b0;
         ddram_we_q   <= 1'b0;
         ddram_addr_q <= 29'd0;
         ddram_din_q  <= 64'd0;
         ddram_be_q   <= 8'd0;
      end else begin
         rd_hist_q <= rd;
         wr_hist_q <= wr;
         case (state_q)
            IDLE: begin
               // a write edge masks a simultaneous read edge
               if (wr_edge) begin
                  req_tag_q    <= addr[20:3];
                  req_sel_q    <= addr[2:0];
                  ddram_addr_q <= DDR_BASE | {11'd0, addr[20:3]};
                  ddram_din_q  <= {8{din}};
                  ddram_be_q   <= 8'b1 << addr[2:0];
                  ddram_we_q   <= 1'b1;
                  ready_q      <= 1'b0;
                  state_q      <= WR_REQ;
                  if (hit) line_q <= put_byte(line_q, addr[2:0], din);
               end else if (rd_edge) begin
                  if (hit) begin
                     dout_q <= get_byte(line_q, addr[2:0]);
                  end else begin
                     req_tag_q    <= addr[20:3];
                     req_sel_q    <= addr[2:0];
                     ddram_addr_q <= DDR_BASE | {11'd0, addr[20:3]};
                     ddram_rd_q   <= 1'b1;
                     ready_q      <= 1'b0;
                     state_q      <= RD_REQ;
                  end
               end
            end
            RD_REQ: begin
               if (!DDRAM_BUSY) begin
                  ddram_rd_q <= 1'b0;
                  state_q    <= RD_WAIT;
               end
            end
            RD_WAIT: begin
               if (DDRAM_DOUT_READY) begin
                  line_q  <= DDRAM_DOUT;
                  tag_q   <= req_tag_q;
                  valid_q <= 1'b1;
                  dout_q  <= get_byte(DDRAM_DOUT, req_sel_q);
                  ready_q <= 1'b1;
                  state_q <= IDLE;
               end
            end
            WR_REQ: begin
               if (!DDRAM_BUSY) begin
                  ddram_we_q <= 1'b0;
                  ready_q    <= 1'b1;
                  state_q    <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign dout           = dout_q;
   assign ready          = ready_q;
   assign DDRAM_BURSTCNT = 8'd1;
   assign DDRAM_ADDR     = ddram_addr_q;
   assign DDRAM_RD       = ddram_rd_q;
   assign DDRAM_DIN      = ddram_din_q;
   assign DDRAM_BE       = ddram_be_q;
   assign DDRAM_WE       = ddram_we_q;

endmodule

// File: tb/tb_gs_ddram_bridge.sv
// Bench for gs_ddram_bridge: a DDRAM memory model plus GS-side expectations
// derived from memory contents and a one-line cache hit model.
`timescale 1ns/1ps
module tb_gs_ddram_bridge;
   localparam logic [28:0] BASE = 29'h6000000;

   logic        clk_sys = 1'b0;
   logic        reset = 1'b1;
   logic [20:0] addr = '0;
   logic [7:0]  din = '0;
   logic [7:0]  dout;
   logic        rd = 1'b0;
   logic        wr = 1'b0;
   logic        ready;
   logic        DDRAM_BUSY;
   logic [7:0]  DDRAM_BURSTCNT;
   logic [28:0] DDRAM_ADDR;
   logic [63:0] DDRAM_DOUT;
   logic        DDRAM_DOUT_READY;
   logic        DDRAM_RD;
   logic [63:0] DDRAM_DIN;
   logic [7:0]  DDRAM_BE;
   logic        DDRAM_WE;

   gs_ddram_bridge #(.DDR_BASE(BASE)) dut (
      .clk_sys(clk_sys), .reset(reset), .addr(addr), .din(din), .dout(dout),
      .rd(rd), .wr(wr), .ready(ready), .DDRAM_BUSY(DDRAM_BUSY),
      .DDRAM_BURSTCNT(DDRAM_BURSTCNT), .DDRAM_ADDR(DDRAM_ADDR),
      .DDRAM_DOUT(DDRAM_DOUT), .DDRAM_DOUT_READY(DDRAM_DOUT_READY),
      .DDRAM_RD(DDRAM_RD), .DDRAM_DIN(DDRAM_DIN), .DDRAM_BE(DDRAM_BE),
      .DDRAM_WE(DDRAM_WE)
   );

   always #5 clk_sys = ~clk_sys;

   int errors = 0;
   int checks = 0;

   // DDRAM model state
   logic [63:0] mem [logic [28:0]];
   int          busy_left = 0;
   int          lat = 1;
   int          resp_cnt = 0;
   logic [28:0] resp_addr = '0;
   int          rd_cmds = 0;
   int          wr_cmds = 0;
   int          rd_busy_cycles = 0;
   int          ready_pulses = 0;
   logic [28:0] exp_cmd_addr = '0;
   logic [28:0] last_rd_addr = '0;
   logic [28:0] last_wr_addr = '0;
   logic [63:0] last_wr_din = '0;
   logic [7:0]  last_wr_be = '0;

   // GS-side cache model: which line the bridge should be holding
   logic        m_valid = 1'b0;
   logic [17:0] m_tag = '0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [63:0] get_word(input logic [28:0] w);
      if (!mem.exists(w)) mem[w] = {$urandom, $urandom};
      return mem[w];
   endfunction

   function automatic logic [7:0] gs_byte(input logic [20:0] a);
      logic [63:0] word;
      word = get_word(BASE | {11'd0, a[20:3]});
      return word[{a[2:0], 3'b000} +: 8];
   endfunction

   // DDRAM responder and per-cycle bus checks, evaluated just after each rising edge
   initial begin
      logic [63:0] wv;
      DDRAM_BUSY = 1'b0;
      DDRAM_DOUT = '0;
      DDRAM_DOUT_READY = 1'b0;
      forever begin
         @(posedge clk_sys);
         #2;
         DDRAM_DOUT_READY = 1'b0;
         if (resp_cnt > 0) begin
            resp_cnt--;
            if (resp_cnt == 0) begin
               DDRAM_DOUT = get_word(resp_addr);
               DDRAM_DOUT_READY = 1'b1;
               ready_pulses++;
            end
         end
         if ((DDRAM_RD || DDRAM_WE) && busy_left > 0) begin
            DDRAM_BUSY = 1'b1;
            busy_left--;
         end else begin
            DDRAM_BUSY = 1'b0;
         end
         check("burstcnt", 64'(DDRAM_BURSTCNT), 64'd1);
         if (DDRAM_RD || DDRAM_WE) begin
            check("cmd_addr", 64'(DDRAM_ADDR), 64'(exp_cmd_addr));
            check("rd_we_excl", 64'(DDRAM_RD & DDRAM_WE), 64'd0);
         end
         if (DDRAM_RD && DDRAM_BUSY) rd_busy_cycles++;
         if (DDRAM_RD && !DDRAM_BUSY) begin
            rd_cmds++;
            last_rd_addr = DDRAM_ADDR;
            resp_addr = DDRAM_ADDR;
            resp_cnt = lat;
         end
         if (DDRAM_WE && !DDRAM_BUSY) begin
            wr_cmds++;
            last_wr_addr = DDRAM_ADDR;
            last_wr_din = DDRAM_DIN;
            last_wr_be = DDRAM_BE;
            wv = get_word(DDRAM_ADDR);
            for (int k = 0; k < 8; k++)
               if (DDRAM_BE[k]) wv[8*k +: 8] = DDRAM_DIN[8*k +: 8];
            mem[DDRAM_ADDR] = wv;
         end
      end
   end

   task automatic do_read(input logic [20:0] a, input int b, input int l);
      logic       exp_miss;
      logic [7:0] exp_b;
      int         r0, lowc;
      exp_miss = !(m_valid && m_tag == a[20:3]);
      exp_b = gs_byte(a);
      r0 = rd_cmds;
      exp_cmd_addr = BASE | {11'd0, a[20:3]};
      busy_left = b;
      lat = l;
      addr = a;
      rd = 1'b1;
      @(negedge clk_sys);
      if (!exp_miss) begin
         check("hit_ready", 64'(ready), 64'd1);
         check("hit_dout", 64'(dout), 64'(exp_b));
      end else begin
         lowc = 0;
         while (!ready && lowc < 200) begin
            lowc++;
            @(negedge clk_sys);
         end
         check("miss_ready_low_cycles", 64'(lowc), 64'(1 + b + l));
         check("miss_dout", 64'(dout), 64'(exp_b));
         m_valid = 1'b1;
         m_tag = a[20:3];
      end
      check("rd_cmd_count", 64'(rd_cmds - r0), 64'(exp_miss));
      rd = 1'b0;
      busy_left = 0;
      @(negedge clk_sys);
   endtask

   task automatic do_write(input logic [20:0] a, input logic [7:0] d, input int b,
                           input logic with_rd);
      int w0, r0, lowc;
      w0 = wr_cmds;
      r0 = rd_cmds;
      exp_cmd_addr = BASE | {11'd0, a[20:3]};
      busy_left = b;
      addr = a;
      din = d;
      wr = 1'b1;
      rd = with_rd;
      @(negedge clk_sys);
      lowc = 0;
      while (!ready && lowc < 200) begin
         lowc++;
         @(negedge clk_sys);
      end
      check("wr_ready_low_cycles", 64'(lowc), 64'(1 + b));
      check("wr_cmd_count", 64'(wr_cmds - w0), 64'd1);
      check("wr_addr", 64'(last_wr_addr), 64'(BASE | {11'd0, a[20:3]}));
      check("wr_be", 64'(last_wr_be), 64'(8'b1 << a[2:0]));
      check("wr_din", last_wr_din, {8{d}});
      if (with_rd) begin
         @(negedge clk_sys);
         check("both_no_read", 64'(rd_cmds - r0), 64'd0);
         check("both_ready", 64'(ready), 64'd1);
      end
      wr = 1'b0;
      rd = 1'b0;
      busy_left = 0;
      @(negedge clk_sys);
   endtask

   initial begin
      #4_000_000;
      $display("FAIL timeout: simulation did not finish, got running expected finished");
      $fatal(1);
   end

   initial begin
      logic [17:0] pool [4];
      logic [20:0] a7;
      int r0, n, dr0, rb0;
      repeat (3) @(negedge clk_sys);
      reset = 1'b0;
      @(negedge clk_sys);
      check("rst_ready", 64'(ready), 64'd1);
      check("rst_dout", 64'(dout), 64'd0);
      check("rst_ddram_rd", 64'(DDRAM_RD), 64'd0);
      check("rst_ddram_we", 64'(DDRAM_WE), 64'd0);
      check("rst_ddram_addr", 64'(DDRAM_ADDR), 64'd0);
      check("rst_ddram_din", DDRAM_DIN, 64'd0);
      check("rst_ddram_be", 64'(DDRAM_BE), 64'd0);

      // read miss then sequential hits
      mem[BASE | 29'd2] = 64'h8877665544332211;
      do_read(21'h00010, 0, 5);
      check("t1_dout", 64'(dout), 64'h11);
      check("t1_ddram_addr", 64'(last_rd_addr), 64'h6000002);
      for (int i = 1; i < 8; i++) begin
         do_read(21'h00010 + 21'(i), 0, 5);
         check("t1_seq_dout", 64'(dout), 64'(8'h11 * 8'(i + 1)));
      end

      // write hit
      do_write(21'h00013, 8'hA5, 0, 1'b0);
      check("t2_be", 64'(last_wr_be), 64'h08);
      check("t2_din", last_wr_din, 64'hA5A5A5A5A5A5A5A5);
      do_read(21'h00013, 0, 5);
      check("t2_dout", 64'(dout), 64'hA5);

      // write miss, no allocate
      do_write(21'h12345, 8'h3C, 0, 1'b0);
      check("t3_addr", 64'(last_wr_addr), 64'h6002468);
      check("t3_be", 64'(last_wr_be), 64'h20);
      do_read(21'h00016, 0, 5);
      check("t3_still_cached", 64'(dout), 64'h77);
      do_read(21'h12345, 0, 4);
      check("t3_dout", 64'(dout), 64'h3C);

      // busy stall on a read miss
      rb0 = rd_busy_cycles;
      r0 = rd_cmds;
      do_read(21'h00800, 10, 3);
      check("t4_busy_cycles", 64'(rd_busy_cycles - rb0), 64'd10);
      check("t4_one_cmd", 64'(rd_cmds - r0), 64'd1);

      // simultaneous edges at the top address
      do_write(21'h1FFFFF, 8'h5A, 2, 1'b1);
      check("t5_addr", 64'(last_wr_addr), 64'h603FFFF);
      check("t5_be", 64'(last_wr_be), 64'h80);

      // reset while waiting for read data
      a7 = 21'h05550;
      exp_cmd_addr = BASE | {11'd0, a7[20:3]};
      lat = 50;
      busy_left = 0;
      r0 = rd_cmds;
      addr = a7;
      rd = 1'b1;
      n = 0;
      while (rd_cmds == r0 && n < 50) begin
         @(negedge clk_sys);
         n++;
      end
      check("t6_issued", 64'(rd_cmds - r0), 64'd1);
      repeat (2) @(negedge clk_sys);
      reset = 1'b1;
      rd = 1'b0;
      @(negedge clk_sys);
      reset = 1'b0;
      m_valid = 1'b0;
      dr0 = ready_pulses;
      resp_cnt = 2;
      repeat (4) begin
         @(negedge clk_sys);
         check("t6_ready", 64'(ready), 64'd1);
         check("t6_dout", 64'(dout), 64'd0);
      end
      check("t6_orphan_seen", 64'(ready_pulses - dr0), 64'd1);
      do_read(a7, 0, 3);

      // randomized traffic over a few lines, with occasional far addresses
      for (int i = 0; i < 4; i++) pool[i] = 18'($urandom);
      pool[3] = 18'h3FFFF;
      for (int i = 0; i < 300; i++) begin
         int op;
         logic [20:0] ra;
         op = $urandom_range(0, 9);
         ra = {pool[$urandom_range(0, 3)], 3'($urandom_range(0, 7))};
         if (op == 9) ra = 21'($urandom);
         if (op < 7) do_read(ra, $urandom_range(0, 3), $urandom_range(1, 6));
         else do_write(ra, 8'($urandom), $urandom_range(0, 3), 1'b0);
         repeat ($urandom_range(0, 2)) @(negedge clk_sys);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/gs_ddram_bridge.md
Name: gs_ddram_bridge

Overview:
- Bridges the General Sound byte-wide memory port of the tsconf core (21-bit address, up to 2 MB) to the 64-bit high-latency DDRAM interface.
- Sits directly downstream of the tsconf GS_ADDR/GS_DI/GS_DO/GS_RD/GS_WR/GS_WAIT pins; the top level wires GS_WAIT = ~ready.
- Holds a single-line 64-bit read cache so sequential GS fetches hit without DDRAM latency.
- Writes are write-through, no-allocate, with a one-byte lane enable.

Parameters:
- DDR_BASE, 29'h6000000: DDRAM word address (64-bit words) of GS byte 0, i.e. byte 0x30000000. Bits [17:0] must be zero.

Ports:
- clk_sys  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- addr  in  21  GS byte address.
- din  in  8  write data from GS.
- dout  out  8  read data to GS.
- rd  in  1  GS read request, level.
- wr  in  1  GS write request, level.
- ready  out  1  1 = access complete / idle; 0 = GS must wait.
- DDRAM_BUSY  in  1  DDRAM not accepting a command.
- DDRAM_BURSTCNT  out  8  constant 1.
- DDRAM_ADDR  out  29  word address.
- DDRAM_DOUT  in  64  read data.
- DDRAM_DOUT_READY  in  1  read data valid strobe.
- DDRAM_RD  out  1  read command.
- DDRAM_DIN  out  64  write data.
- DDRAM_BE  out  8  byte enables.
- DDRAM_WE  out  1  write command.

Behaviour:
- Reset values: dout=0, ready=1, DDRAM_RD=0, DDRAM_WE=0, DDRAM_ADDR=0, DDRAM_DIN=0, DDRAM_BE=0, cache valid=0, state=IDLE. rd_d/wr_d are cleared, so a level held high through reset produces a strobe on the first cycle after reset.
- Strobes: rd_edge = rd & ~rd_d; wr_edge = wr & ~wr_d (registered history).
  - Strobes are evaluated only in IDLE; strobes arriving in other states are dropped.
  - GS holds rd/wr until ready returns.
  - Both edges in the same cycle: write wins, read is ignored.
- Cache: line[63:0], tag[17:0] = addr[20:3], valid.
  - hit = valid & (tag == addr[20:3]).
  - Byte select = addr[2:0]; byte k = line[8k+7:8k].
- DDRAM_ADDR = DDR_BASE | addr[20:3], taken from the address captured with the request. DDRAM_BURSTCNT = 8'd1.
- States:
  - IDLE
    - rd_edge & hit: dout <= selected line byte at edge N+1; ready stays 1; state stays IDLE.
    - rd_edge & miss: capture addr; ready <= 0; DDRAM_RD <= 1; go RD_REQ.
    - wr_edge: capture addr;
      - DDRAM_DIN <= {8{din}}; DDRAM_BE <= 8'b1 << addr[2:0]; DDRAM_WE <= 1; ready <= 0; go WR_REQ.
      - If hit, update the line byte in the same cycle. Miss: no allocate.
  - RD_REQ: hold DDRAM_RD=1 while DDRAM_BUSY. On the first cycle with !DDRAM_BUSY, the command is accepted: DDRAM_RD <= 0; go RD_WAIT.
  - RD_WAIT: on DDRAM_DOUT_READY:
    - line <= DDRAM_DOUT; tag <= captured addr[20:3]; valid <= 1.
    - dout <= selected byte of DDRAM_DOUT; ready <= 1; go IDLE.
  - WR_REQ: hold DDRAM_WE=1 while DDRAM_BUSY. When !DDRAM_BUSY: DDRAM_WE <= 0; ready <= 1; go IDLE.
- Latency:
  - Read hit: 1 cycle, ready never drops.
  - Read miss: 1 cycle + busy stall + DDRAM latency + 1.
  - Write: minimum 2 cycles (ready low at least 1 cycle).
- ready is registered. It falls at edge N+1 after a strobe seen in cycle N, and rises on the same edge dout is updated.
- DDRAM_DOUT_READY outside RD_WAIT is ignored and must not alter the line or dout.
- reset mid-operation:
  - Immediate return to IDLE; all outputs take their reset values; cache invalidated.
  - A DDRAM read already issued may return data later; it is ignored (IDLE).
- Address wrap: addr 21'h1FFFFF maps to word DDR_BASE|18'h3FFFF, byte 7. No carry into DDR_BASE bits.
- Bytes above the configured GS size are masked by the top level; this block treats all 2 MB uniformly.

Test Plan:
- Read miss then sequential hits: reset; DDRAM model returns 64'h8877665544332211 after 5 cycles.
  - rd at addr 0x00010 -> one DDRAM_RD, DDRAM_ADDR=0x6000002, ready low until data, dout=0x11.
  - Reads at 0x00011..0x00017 -> dout 0x22..0x88, ready stays 1, no DDRAM_RD.
- Write hit: after the line above is cached, wr addr 0x00013 din 0xA5.
  - DDRAM_WE with DDRAM_BE=8'h08, DDRAM_DIN=64'hA5A5A5A5A5A5A5A5.
  - A following rd of 0x00013 returns 0xA5 with no DDRAM_RD.
- Write miss, no allocate: wr 0x12345 din 0x3C -> DDRAM_ADDR=0x6002468, BE=8'h20, valid/tag unchanged. A later rd of 0x12345 issues DDRAM_RD.
- Busy stall: DDRAM_BUSY held high 10 cycles on a read miss.
  - DDRAM_RD stays 1 for all 10 cycles and drops the cycle after BUSY falls.
  - Exactly one command is accepted; ready stays 0 throughout.
- Simultaneous rd/wr edges and wrap: rd and wr rise together at 0x1FFFFF -> only a write, DDRAM_ADDR=0x603FFFF, BE=8'h80.
- Reset in RD_WAIT: DOUT_READY arrives 2 cycles after reset releases.
  - ready=1; dout, line and valid unchanged (valid=0).
  - A next rd of the same address issues a fresh DDRAM_RD.
